// File: rtl/zero_extend_8b_pkg.sv
// Shared datapath widths and types for the 16-bit core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package zero_extend_8b_pkg;

    // Native datapath word and byte widths.
    localparam int DATA_W = 16;
    localparam int BYTE_W = 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [BYTE_W-1:0] byte_t;

endpackage : zero_extend_8b_pkg

// File: rtl/zero_extend_8b_zext_comb.sv
// Purely combinational zero extender, IN_W bits up to OUT_W bits.
// Latency: zero, the output follows the input in the same delta.
// Backpressure: none; there is no handshake on this path.
module zext_comb #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  in_dat,
    output logic [OUT_W-1:0] out_dat
);

    // Refuse to build an extender that would truncate or has no input.
    if (IN_W < 1) begin : g_bad_in_w
        $error("zext_comb: IN_W must be at least 1");
    end
    if (OUT_W < IN_W) begin : g_bad_out_w
        $error("zext_comb: OUT_W must be at least IN_W");
    end

    // Equal widths need no padding; otherwise pad the top with zeros.
    // X/Z on in_dat stay confined to the low bits, the pad is always 0.
    if (OUT_W == IN_W) begin : g_pass
        assign out_dat = in_dat;
    end else begin : g_pad
        assign out_dat = {{(OUT_W-IN_W){1'b0}}, in_dat};
    end

endmodule : zext_comb

// File: rtl/zero_extend_8b.sv
// Zero-extends a byte to a datapath word, combinational plus a registered copy.
// Latency: out is zero-latency; out_q/out_valid follow in/in_valid by 1 cycle.
// Backpressure: none; every in_valid cycle yields one out_valid cycle.
module zero_extend_8b
    import zero_extend_8b_pkg::*;
#(
    parameter int IN_W  = BYTE_W,
    parameter int OUT_W = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid,
    output logic             err
);

    if (IN_W < 1) begin : g_bad_in_w
        $error("zero_extend_8b: IN_W must be at least 1");
    end
    if (OUT_W < IN_W) begin : g_bad_out_w
        $error("zero_extend_8b: OUT_W must be at least IN_W");
    end

    logic [OUT_W-1:0] ext_dat;

    // Registered result, its valid tag, the raw byte it was built from
    // (kept separately so the self-check compares against the source, not
    // against the extender's own output) and the sticky error flag.
    logic [OUT_W-1:0] data_q,  data_d;
    logic             valid_q, valid_d;
    logic [IN_W-1:0]  cap_q,   cap_d;
    logic             err_q,   err_d;
    logic             chk_fail;

    zext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_zext (
        .in_dat  (in),
        .out_dat (ext_dat)
    );

    // Combinational result is independent of clk and rst.
    assign out = ext_dat;

    // Next-state for the pipeline register and the self-check.
    always_comb begin
        data_d  = data_q;
        cap_d   = cap_q;
        valid_d = 1'b0;
        if (in_valid) begin
            data_d  = ext_dat;
            cap_d   = in;
            valid_d = 1'b1;
        end
        // A valid result must have a clear pad and carry the captured byte.
        chk_fail = valid_q &&
                   (((data_q >> IN_W) != '0) || (data_q[IN_W-1:0] != cap_q));
        err_d    = err_q | chk_fail;
    end

    // State register; reset clears everything at once, regardless of clk.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            cap_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            cap_q   <= cap_d;
            err_q   <= err_d;
        end
    end

    assign out_q     = data_q;
    assign out_valid = valid_q;
    assign err       = err_q;

endmodule : zero_extend_8b

// File: tb/tb_zero_extend_8b.sv
// Self-checking bench for zero_extend_8b with a value-level reference model.
// Latency: expects out at zero latency, out_q/out_valid one edge after input.
// Backpressure: none exercised; the DUT has no ready.
module tb_zero_extend_8b;

    logic        clk;
    logic        rst;
    logic [7:0]  in;
    logic        in_valid;
    logic [15:0] out;
    logic [15:0] out_q;
    logic        out_valid;
    logic        err;

    int n_chk;
    int n_err;

    // Reference model state: the numeric value last accepted and its tag.
    int exp_q;
    bit exp_vld;

    zero_extend_8b dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_q     (out_q),
        .out_valid (out_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drive one cycle's inputs just after a falling edge, let a rising edge
    // happen, advance the model, then check everything on the next fall.
    task automatic cycle(input string tag, input bit v, input int d);
        in_valid = v;
        in       = d[7:0];
        @(posedge clk);
        if (v) begin
            exp_q   = d;
            exp_vld = 1'b1;
        end else begin
            exp_vld = 1'b0;
        end
        @(negedge clk);
        check_eq({tag, ".out"},       {16'h0, out},       d);
        check_eq({tag, ".out_q"},     {16'h0, out_q},     exp_q);
        check_eq({tag, ".out_valid"}, {31'h0, out_valid}, {31'h0, exp_vld});
        check_eq({tag, ".err"},       {31'h0, err},       32'h0);
    endtask

    initial begin
        n_chk    = 0;
        n_err    = 0;
        exp_q    = 0;
        exp_vld  = 1'b0;
        rst      = 1'b1;
        in       = 8'h00;
        in_valid = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst.out_q",     {16'h0, out_q},     32'h0);
        check_eq("rst.out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst.err",       {31'h0, err},       32'h0);
        rst = 1'b0;

        // Combinational sweep: the result is the byte's numeric value.
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            in = i[7:0];
            #1;
            check_eq("sweep.out", {16'h0, out}, i);
        end
        in = 8'h80;
        #1;
        check_eq("no_sign_ext", {16'h0, out}, 32'h80);

        // Registered latency and hold behaviour.
        @(negedge clk);
        cycle("lat_n",  1'b1, 'h3C);
        cycle("lat_n1", 1'b0, 'hC3);

        // Back-to-back valid cycles with boundary values.
        cycle("b2b0", 1'b1, 'h00);
        cycle("b2b1", 1'b1, 'hFF);
        cycle("b2b2", 1'b1, 'h01);

        // Async reset mid-stream, asserted between edges.
        cycle("pre_rst", 1'b1, 'h5A);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst.out_q",     {16'h0, out_q},     32'h0);
        check_eq("arst.out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("arst.err",       {31'h0, err},       32'h0);
        check_eq("arst.out",       {16'h0, out},       32'h5A);
        exp_q   = 0;
        exp_vld = 1'b0;
        // in_valid is ignored while rst is held across an edge.
        in_valid = 1'b1;
        in       = 8'hE7;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_hold.out_valid", {31'h0, out_valid}, 32'h0);
        check_eq("rst_hold.out_q",     {16'h0, out_q},     32'h0);
        check_eq("rst_hold.out",       {16'h0, out},       32'hE7);
        rst = 1'b0;
        cycle("post_rst0", 1'b0, 'h77);
        cycle("post_rst1", 1'b1, 'h80);

        // Random soak against the model.
        for (int i = 0; i < 100; i++) begin
            cycle("soak", 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule : tb_zero_extend_8b
